// File: rtl/serial_pkg.sv
// Shared definitions for the serial RX/TX family: FSM state encoding,
// parity sense constants and a constant-safe ceil(log2) helper.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_rx_filter.sv
// RX line front end: two-flop synchroniser followed by a 2-bit saturating
// hysteresis counter, all advancing on baud_tick. Delay is fixed in both directions.
module serial_rx_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  input  logic baud_tick,
  output logic rxf
);

  logic       sync1_q, sync2_q;
  logic [1:0] cnt_q, cnt_d;
  logic       rxf_q, rxf_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q && (cnt_q != 2'b11)) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!sync2_q && (cnt_q != 2'b00)) begin
      cnt_d = cnt_q - 2'd1;
    end
    rxf_d = rxf_q;
    if (cnt_d == 2'b00) begin
      rxf_d = 1'b0;
    end else if (cnt_d == 2'b11) begin
      rxf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= 2'b11;
      rxf_q   <= 1'b1;
    end else if (baud_tick) begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      rxf_q   <= rxf_d;
    end
  end

  assign rxf = rxf_q;

endmodule

// File: rtl/serial_arx_p.sv
// Parametrised async serial receiver with parity, framing/break detection
// and an inter-character gap timer that marks end of packet.
//   state    | meaning
//   IDLE     | line high, waiting for start edge; gap timer runs
//   START    | qualifying start bit at its midpoint (false-start reject)
//   DATA     | sampling DATA_BITS data bits, LSB first
//   PARITY   | sampling the parity bit
//   STOP     | sampling stop bit, issuing result pulses
//   BRK_WAIT | break seen, holding until the line returns high
module serial_arx_p
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int GAP_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 baud_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 rx_idle,
  output logic                 rx_eop
);

  localparam int TW = clog2(OVERSAMPLE);
  localparam int BW = clog2(DATA_BITS + 1);
  localparam int GW = clog2(GAP_TICKS + 1);
  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BI_LAST = BW'(DATA_BITS - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TICKS);
  localparam logic [GW-1:0] GAP_PRE = GW'(GAP_TICKS - 1);
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic rxf;
  rx_state_e state_q, state_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [BW-1:0] bi_q, bi_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic par_q, par_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic [GW-1:0] gap_q, gap_d;
  logic idle_q, eop_q, eop_d;
  logic brk_cond;

  serial_rx_filter u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .baud_tick (baud_tick),
    .rxf       (rxf)
  );

  assign brk_cond = (sh_q == '0) && ((PARITY_EN == 0) || !par_q);

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    bi_d    = bi_q;
    sh_d    = sh_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxf) begin
            state_d = ST_START;
            tc_d    = '0;
          end
        end
        ST_START: begin
          if (tc_q == TC_HALF) begin
            if (rxf) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              tc_d    = '0;
              bi_d    = '0;
            end
          end else begin
            tc_d = tc_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tc_q == TC_LAST) begin
            sh_d = {rxf, sh_q[DATA_BITS-1:1]};
            tc_d = '0;
            bi_d = bi_q + BW'(1);
            if (bi_q == BI_LAST) begin
              state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
          end else begin
            tc_d = tc_q + TW'(1);
          end
        end
        ST_PARITY: begin
          if (tc_q == TC_LAST) begin
            par_d   = rxf;
            tc_d    = '0;
            state_d = ST_STOP;
          end else begin
            tc_d = tc_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (tc_q == TC_LAST) begin
            tc_d   = '0;
            data_d = sh_q;
            if (rxf) begin
              valid_d = 1'b1;
              perr_d  = (PARITY_EN != 0) && ((^sh_q) ^ par_q ^ PAR_SENSE);
              state_d = ST_IDLE;
            end else begin
              ferr_d = 1'b1;
              brk_d  = brk_cond;
              // A break holds off re-arming until the line is released.
              state_d = brk_cond ? ST_BRK_WAIT : ST_IDLE;
            end
          end else begin
            tc_d = tc_q + TW'(1);
          end
        end
        ST_BRK_WAIT: begin
          if (rxf) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    gap_d = gap_q;
    if (state_q != ST_IDLE) begin
      gap_d = '0;
    end else if (baud_tick && (gap_q != GAP_MAX)) begin
      gap_d = gap_q + GW'(1);
    end
    eop_d = (gap_q == GAP_PRE) && (gap_d == GAP_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tc_q    <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      gap_q   <= GAP_MAX;
      idle_q  <= 1'b1;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      bi_q    <= bi_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      gap_q   <= gap_d;
      idle_q  <= (gap_d == GAP_MAX);
      eop_q   <= eop_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign rx_idle    = idle_q;
  assign rx_eop     = eop_q;

endmodule
